veririsc_controller: RTL and testbench
======================================

// Module: veririsc_controller
// PURPOSE
//  Instruction sequencer for the VeriRISC core; sits beside the ALU and consumes its zero flag.
//  Steps an 8-phase cycle per instruction and decodes the 3-bit opcode into datapath strobes:
//  memory select/read/write, IR load, PC inc/load, accumulator load and data-bus enable.
//  Handles HLT (0), SKZ (1), ADD (2), AND (3), XOR (4), LDA (5), STO (6) and JMP (7).
// PARAMETERS
//  OPC_W    3   opcode width (fixed by the ISA; not meant to be overridden)
//  PHASE_W  3   phase counter width (8 phases)
// PORTS
//  clk     in   1        rising-edge clock
//  rst_n   in   1        asynchronous, active-low reset
//  opcode  in   OPC_W    IR[7:5]; valid from phase OP_ADDR onward
//  zero    in   1        ALU a_is_zero (accumulator == 0), sampled in ALU_OP
//  sel     out  1        1 = PC drives the memory address, 0 = IR operand field
//  rd      out  1        memory read
//  wr      out  1        memory write
//  ld_ir   out  1        load instruction register
//  inc_pc  out  1        increment PC
//  ld_pc   out  1        load PC from the IR operand field
//  ld_ac   out  1        load accumulator from ALU output
//  data_e  out  1        drive the accumulator onto the data bus
//  halt    out  1        processor halted
//  phase   out  PHASE_W  current phase (debug and bench visibility)
// BEHAVIOUR
//  - The phase register advances +1 every clk and wraps from 7 to 0. Outputs are combinational
//    from {phase, opcode, zero}, so each strobe is valid for exactly one cycle per phase.
//  - Reset (rst_n=0, asynchronous): phase=0 (INST_ADDR), halted flag=0.
//    Outputs during reset: sel=1, all other strobes 0, halt=0.
//  - ALUOP = opcode in {ADD, AND, XOR, LDA}.
//  - Output decode per phase (strobes not listed are 0):
//     0 INST_ADDR : sel
//     1 INST_FETCH: sel, rd
//     2 INST_LOAD : sel, rd, ld_ir
//     3 IDLE      : sel, rd, ld_ir
//     4 OP_ADDR   : inc_pc; halt=(opcode==HLT)
//     5 OP_FETCH  : rd=ALUOP
//     6 ALU_OP    : rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP);
//                   data_e=(opcode==STO)
//     7 STORE     : rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); inc_pc=(opcode==JMP);
//                   wr=(opcode==STO); data_e=(opcode==STO)
//  - HLT: in OP_ADDR with opcode==HLT, the halted flag sets on that clock edge.
//    While halted: phase frozen at OP_ADDR, halt=1, every other strobe 0 (no further PC increments).
//  - SKZ with zero=0, and HLT/SKZ in STORE: no strobes asserted.
//  - wr and rd are never asserted together; ld_pc and sel are never asserted together.
//  - rst_n asserted mid-instruction: phase returns to INST_ADDR immediately and halted clears.
//    No partial strobe sequence is resumed.
// CONFIGURATION
//  Macro VERIRISC_HALT_RESUME_EN:
//   defined  : adds input `resume` (1 bit). A resume=1 sampled while halted clears the halted flag;
//              the next phase is INST_ADDR. resume is ignored when not halted.
//   undefined: no resume port; halt is sticky until rst_n.
// STRUCTURE
//  - veririsc_pkg: opcode localparams (HLT..JMP) and phase localparams (INST_ADDR..STORE).
//    Shared with the ALU and the bench.
//  - Sub-module veririsc_ctrl_decode: purely combinational {phase, opcode, zero, halted} -> strobes.
//  - The top level holds only the phase counter and the halted flag.
// TESTING
//  1 Reset, then ADD: rst_n low -> phase=0, sel=1, others 0. Release with opcode=2 ->
//    ld_ir=1 in phases 2-3, inc_pc=1 in phase 4, rd=1 in phases 5-7, ld_ac=1 in phase 7 only.
//  2 STO (opcode=6) -> data_e=1 in phases 6-7, wr=1 in phase 7 only, rd=0 in phases 5-7.
//  3 SKZ (opcode=1): zero=1 -> inc_pc=1 in phase 6. zero=0 -> inc_pc=0 in phase 6.
//  4 JMP (opcode=7) -> ld_pc=1 in phases 6-7, inc_pc=1 in phase 7, sel=0 throughout phases 4-7.
//  5 HLT (opcode=0) -> halt=1 at phase 4; phase holds 4 for 20 cycles with inc_pc=0.
//    With the macro, resume=1 -> phase=0 next cycle and halt=0.
//  6 rst_n pulsed low in phase 6 with opcode=6 -> asynchronous phase=0 and wr never asserted.
//    Normal fetch restarts after release.

Source files
------------

// File: rtl/veririsc_pkg.sv
// -----------------------------------------------------------------------------
// veririsc_pkg
//   Shared definitions for the VeriRISC core: ISA opcodes, the 8-phase
//   instruction cycle encoding and a small ALU-op classifier. Used by the
//   controller, the ALU and the bench.
//   No ports (package).
// -----------------------------------------------------------------------------
package veririsc_pkg;

   localparam int OPC_W   = 3;   // opcode width, fixed by the ISA
   localparam int PHASE_W = 3;   // 8 phases per instruction

   // Opcodes (IR[7:5])
   localparam logic [OPC_W-1:0] HLT = 3'd0;
   localparam logic [OPC_W-1:0] SKZ = 3'd1;
   localparam logic [OPC_W-1:0] ADD = 3'd2;
   localparam logic [OPC_W-1:0] AND = 3'd3;
   localparam logic [OPC_W-1:0] XOR = 3'd4;
   localparam logic [OPC_W-1:0] LDA = 3'd5;
   localparam logic [OPC_W-1:0] STO = 3'd6;
   localparam logic [OPC_W-1:0] JMP = 3'd7;

   // Instruction-cycle phases
   typedef enum logic [PHASE_W-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   // Instructions whose result comes back through the ALU into the accumulator
   function automatic logic is_aluop(input logic [OPC_W-1:0] op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/veririsc_controller_if.sv
// -----------------------------------------------------------------------------
// veririsc_controller_if
//   Bundles the controller <-> datapath signals.
//   master : controller side (drives strobes, halt, phase; reads opcode, zero
//            and, when VERIRISC_HALT_RESUME_EN is defined, resume)
//   slave  : datapath side (mirror image)
//   Signals: opcode, zero, [resume], sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac,
//            data_e, halt, phase.
//   Macro: VERIRISC_HALT_RESUME_EN adds the resume signal.
// -----------------------------------------------------------------------------
interface veririsc_controller_if;
   import veririsc_pkg::*;

   logic [OPC_W-1:0]   opcode;
   logic               zero;
`ifdef VERIRISC_HALT_RESUME_EN
   logic               resume;
`endif
   logic               sel;
   logic               rd;
   logic               wr;
   logic               ld_ir;
   logic               inc_pc;
   logic               ld_pc;
   logic               ld_ac;
   logic               data_e;
   logic               halt;
   logic [PHASE_W-1:0] phase;

`ifdef VERIRISC_HALT_RESUME_EN
   modport master (
      input  opcode, zero, resume,
      output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase
   );
   modport slave (
      output opcode, zero, resume,
      input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase
   );
`else
   modport master (
      input  opcode, zero,
      output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase
   );
   modport slave (
      output opcode, zero,
      input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase
   );
`endif

endinterface

// File: rtl/veririsc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// veririsc_ctrl_decode
//   Purely combinational strobe decode from {phase, opcode, zero, halted}.
//   Inputs : phase, opcode, zero (accumulator == 0), halted (sticky halt flag)
//   Outputs: sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt
// -----------------------------------------------------------------------------
module veririsc_ctrl_decode
   import veririsc_pkg::*;
(
   input  phase_t           phase,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   input  logic             halted,
   output logic             sel,
   output logic             rd,
   output logic             wr,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             ld_pc,
   output logic             ld_ac,
   output logic             data_e,
   output logic             halt
);

   logic alu_op;
   assign alu_op = is_aluop(opcode);

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;

      if (halted) begin
         // Frozen: only halt is visible so the PC cannot creep forward.
         halt = 1'b1;
      end else begin
         unique case (phase)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == HLT);
            end
            OP_FETCH: begin
               rd = alu_op;
            end
            ALU_OP: begin
               rd     = alu_op;
               inc_pc = (opcode == SKZ) && zero;
               ld_pc  = (opcode == JMP);
               data_e = (opcode == STO);
            end
            STORE: begin
               rd     = alu_op;
               ld_ac  = alu_op;
               ld_pc  = (opcode == JMP);
               inc_pc = (opcode == JMP);
               wr     = (opcode == STO);
               data_e = (opcode == STO);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/veririsc_controller.sv
// -----------------------------------------------------------------------------
// veririsc_controller
//   Instruction sequencer for the VeriRISC core. Holds the 8-phase counter and
//   the halted flag; strobe decode lives in veririsc_ctrl_decode.
//   Ports: clk   - rising-edge clock
//          rst_n - asynchronous active-low reset
//          bus   - veririsc_controller_if.master (opcode/zero in, strobes,
//                  halt and phase out, optional resume in)
//   Macro: VERIRISC_HALT_RESUME_EN - when defined, resume=1 while halted
//          restarts the cycle at INST_ADDR; otherwise halt is sticky.
// -----------------------------------------------------------------------------
module veririsc_controller
   import veririsc_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   veririsc_controller_if.master  bus
);

   phase_t phase_reg, phase_next;
   logic   halted_reg, halted_next;
   logic   resume_req;

`ifdef VERIRISC_HALT_RESUME_EN
   assign resume_req = bus.resume;
`else
   assign resume_req = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg  <= INST_ADDR;
         halted_reg <= 1'b0;
      end else begin
         phase_reg  <= phase_next;
         halted_reg <= halted_next;
      end
   end

   always_comb begin
      phase_next  = phase_reg;
      halted_next = halted_reg;
      if (halted_reg) begin
         // Phase stays parked at OP_ADDR until a resume (if built in).
         if (resume_req) begin
            halted_next = 1'b0;
            phase_next  = INST_ADDR;
         end
      end else if (phase_reg == OP_ADDR && bus.opcode == HLT) begin
         // Halt takes effect on this edge; phase does not advance.
         halted_next = 1'b1;
      end else begin
         phase_next = phase_t'(phase_reg + PHASE_W'(1));
      end
   end

   veririsc_ctrl_decode u_decode (
      .phase  (phase_reg),
      .opcode (bus.opcode),
      .zero   (bus.zero),
      .halted (halted_reg),
      .sel    (bus.sel),
      .rd     (bus.rd),
      .wr     (bus.wr),
      .ld_ir  (bus.ld_ir),
      .inc_pc (bus.inc_pc),
      .ld_pc  (bus.ld_pc),
      .ld_ac  (bus.ld_ac),
      .data_e (bus.data_e),
      .halt   (bus.halt)
   );

   assign bus.phase = phase_reg;

endmodule

// File: tb/tb_veririsc_controller.sv
// -----------------------------------------------------------------------------
// tb_veririsc_controller
//   Directed bench for veririsc_controller. Strobes are compared as a packed
//   vector {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt} against
//   hand-written per-phase tables. Honours VERIRISC_HALT_RESUME_EN.
// -----------------------------------------------------------------------------
module tb_veririsc_controller;
   import veririsc_pkg::*;

   // Strobe vector bits: sel rd wr ld_ir inc_pc ld_pc ld_ac data_e halt
   localparam logic [8:0] S_SEL   = 9'b100000000;
   localparam logic [8:0] S_FETCH = 9'b110000000;
   localparam logic [8:0] S_LOAD  = 9'b110100000;
   localparam logic [8:0] S_INC   = 9'b000010000;
   localparam logic [8:0] S_NONE  = 9'b000000000;
   localparam logic [8:0] S_HALT  = 9'b000000001;

   // Tables packed phase 7 down to phase 0
   localparam logic [71:0] EXP_ALU = {9'b010000100, 9'b010000000, 9'b010000000, S_INC,
                                      S_LOAD, S_LOAD, S_FETCH, S_SEL};
   localparam logic [71:0] EXP_STO = {9'b001000010, 9'b000000010, S_NONE, S_INC,
                                      S_LOAD, S_LOAD, S_FETCH, S_SEL};
   localparam logic [71:0] EXP_SKZ1 = {S_NONE, 9'b000010000, S_NONE, S_INC,
                                       S_LOAD, S_LOAD, S_FETCH, S_SEL};
   localparam logic [71:0] EXP_SKZ0 = {S_NONE, S_NONE, S_NONE, S_INC,
                                       S_LOAD, S_LOAD, S_FETCH, S_SEL};
   localparam logic [71:0] EXP_JMP = {9'b000011000, 9'b000001000, S_NONE, S_INC,
                                      S_LOAD, S_LOAD, S_FETCH, S_SEL};

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   veririsc_controller_if bus();

   veririsc_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [8:0] strobes;
   assign strobes = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.inc_pc,
                     bus.ld_pc, bus.ld_ac, bus.data_e, bus.halt};

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge with phase expected 0; returns at the next phase 0.
   task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                            input logic [71:0] exp);
      bus.opcode = op;
      bus.zero   = z;
      for (int p = 0; p < 8; p++) begin
         chk($sformatf("%s ph%0d phase", name, p), {6'd0, bus.phase}, 9'(p));
         chk($sformatf("%s ph%0d strobes", name, p), strobes, exp[p*9 +: 9]);
         @(negedge clk);
      end
      $display("[TB] instr %s opcode=%0d zero=%0d checked", name, op, z);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b0;
      bus.opcode = ADD;
      bus.zero   = 1'b0;
`ifdef VERIRISC_HALT_RESUME_EN
      bus.resume = 1'b0;
`endif
      #2;
      chk("reset phase", {6'd0, bus.phase}, 9'd0);
      chk("reset strobes", strobes, S_SEL);
      repeat (2) @(negedge clk);
      chk("reset held phase", {6'd0, bus.phase}, 9'd0);
      chk("reset held strobes", strobes, S_SEL);
      $display("[TB] reset checked");
      rst_n = 1'b1;

      run_instr("ADD", ADD, 1'b0, EXP_ALU);
      run_instr("STO", STO, 1'b0, EXP_STO);
      run_instr("SKZ_z1", SKZ, 1'b1, EXP_SKZ1);
      run_instr("SKZ_z0", SKZ, 1'b0, EXP_SKZ0);
      run_instr("JMP", JMP, 1'b0, EXP_JMP);
      run_instr("XOR", XOR, 1'b1, EXP_ALU);
      run_instr("LDA", LDA, 1'b0, EXP_ALU);

      // HLT: fetch phases, then halt visible in OP_ADDR, then frozen
      bus.opcode = HLT;
      bus.zero   = 1'b0;
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("HLT ph%0d phase", p), {6'd0, bus.phase}, 9'(p));
         chk($sformatf("HLT ph%0d strobes", p), strobes, EXP_ALU[p*9 +: 9]);
         @(negedge clk);
      end
      chk("HLT op_addr phase", {6'd0, bus.phase}, 9'd4);
      chk("HLT op_addr strobes", strobes, 9'b000010001);
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("HLT hold%0d phase", c), {6'd0, bus.phase}, 9'd4);
         chk($sformatf("HLT hold%0d strobes", c), strobes, S_HALT);
         @(negedge clk);
      end
      $display("[TB] instr HLT held 20 cycles");

`ifdef VERIRISC_HALT_RESUME_EN
      bus.resume = 1'b1;
      @(negedge clk);
      chk("resume phase", {6'd0, bus.phase}, 9'd0);
      chk("resume strobes", strobes, S_SEL);
      $display("[TB] resume checked");
      // resume held high outside halt must have no effect
      run_instr("ADD_resume_hi", ADD, 1'b0, EXP_ALU);
      bus.resume = 1'b0;
`else
      rst_n = 1'b0;
      #1;
      chk("unhalt reset phase", {6'd0, bus.phase}, 9'd0);
      chk("unhalt reset strobes", strobes, S_SEL);
      @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] halt cleared by reset");
`endif

      // Reset mid-STO in ALU_OP: wr must never appear
      bus.opcode = STO;
      for (int p = 0; p < 6; p++) begin
         chk($sformatf("STOrst ph%0d strobes", p), strobes, EXP_STO[p*9 +: 9]);
         @(negedge clk);
      end
      chk("STOrst ph6 phase", {6'd0, bus.phase}, 9'd6);
      chk("STOrst ph6 strobes", strobes, 9'b000000010);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset phase", {6'd0, bus.phase}, 9'd0);
      chk("async reset strobes", strobes, S_SEL);
      @(posedge clk);
      #1;
      chk("reset over edge wr", {8'd0, bus.wr}, 9'd0);
      chk("reset over edge phase", {6'd0, bus.phase}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] async reset mid-STO checked");
      run_instr("ADD_after_rst", ADD, 1'b0, EXP_ALU);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
